// File: rtl/block_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : block_controller_pkg
// Description : Shared types, default geometry and thread-base helper for the
//               block controller.
// Revision    : 1.0 - initial release
// ============================================================================
package block_controller_pkg;

  localparam int DATA_WIDTH               = 8;
  localparam int DEFAULT_WARPS_PER_CORE   = 4;
  localparam int DEFAULT_THREADS_PER_WARP = 8;

  typedef logic [DATA_WIDTH-1:0] data_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_RUN    = 2'd2,
    S_DONE   = 2'd3
  } block_state_t;

  // First global thread ID of a lane; wraps modulo the data_t width.
  function automatic data_t thread_base(
    input data_t       block_id,
    input data_t       n,
    input int unsigned lane,
    input int unsigned tpw
  );
    logic [31:0] w_full;
    w_full = 32'(block_id) * 32'(n) * tpw + lane * tpw;
    return w_full[DATA_WIDTH-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/block_controller.sv
`default_nettype none
// ============================================================================
// Module      : block_controller
// Description : Launches up to WARPS_PER_CORE warps for one thread block,
//               tracks per-warp completion and reports block done.
// Revision    : 1.0 - initial release
// ============================================================================
module block_controller
  import block_controller_pkg::*;
#(
  parameter int WARPS_PER_CORE   = DEFAULT_WARPS_PER_CORE,
  parameter int THREADS_PER_WARP = DEFAULT_THREADS_PER_WARP
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             core_start,
  input  logic                             core_reset,
  input  data_t                            core_block_id,
  input  data_t                            num_warps,
  output logic                             core_done,
  output logic  [WARPS_PER_CORE-1:0]       warp_start,
  input  logic  [WARPS_PER_CORE-1:0]       warp_done,
  output data_t                            warp_block_id,
  output data_t [WARPS_PER_CORE-1:0]       warp_thread_base,
  output logic                             busy
);

  block_state_t               r_state;
  data_t                      r_block_id;
  data_t                      r_n;
  logic                       r_core_done;
  logic [WARPS_PER_CORE-1:0]  r_warp_start;
  logic [WARPS_PER_CORE-1:0]  r_done_mask;
  logic [WARPS_PER_CORE-1:0]  w_active_mask;
  logic [WARPS_PER_CORE-1:0]  w_done_hit;
  logic [WARPS_PER_CORE-1:0]  w_done_next;
  logic                       w_all_done;
  data_t                      w_n_clamp;

  assign w_n_clamp = (num_warps > data_t'(WARPS_PER_CORE)) ? data_t'(WARPS_PER_CORE)
                                                           : num_warps;

  // Completion is judged on the mask as it will be after this edge, so done
  // rises in the cycle right after the last warp_done is sampled.
  assign w_done_hit  = (r_state == S_RUN) ? (warp_done & w_active_mask) : '0;
  assign w_done_next = r_done_mask | w_done_hit;
  assign w_all_done  = (w_done_next == w_active_mask);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_core_done <= 1'b0;
      r_block_id  <= '0;
      r_n         <= '0;
    end else if (core_reset) begin
      r_state     <= S_IDLE;
      r_core_done <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (core_start) begin
            r_state    <= S_LAUNCH;
            r_block_id <= core_block_id;
            r_n        <= w_n_clamp;
          end
        end
        S_LAUNCH: begin
          if (r_n == '0) begin
            r_state     <= S_DONE;
            r_core_done <= 1'b1;
          end else begin
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_all_done) begin
            r_state     <= S_DONE;
            r_core_done <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_DONE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  for (genvar w = 0; w < WARPS_PER_CORE; w++) begin : g_lane
    logic  r_start;
    logic  r_done;
    data_t r_base;

    assign w_active_mask[w]    = (r_n > data_t'(w));
    assign r_warp_start[w]     = r_start;
    assign r_done_mask[w]      = r_done;
    assign warp_thread_base[w] = r_base;

    always_ff @(posedge clk) begin
      if (!reset) begin
        r_start <= 1'b0;
        r_done  <= 1'b0;
        r_base  <= '0;
      end else if (core_reset) begin
        r_start <= 1'b0;
        r_done  <= 1'b0;
      end else if (r_state == S_LAUNCH) begin
        r_start <= w_active_mask[w];
        r_done  <= 1'b0;
        r_base  <= w_active_mask[w] ? thread_base(r_block_id, r_n, w, THREADS_PER_WARP)
                                    : '0;
      end else if (w_done_hit[w]) begin
        r_start <= 1'b0;
        r_done  <= 1'b1;
      end
    end
  end

  assign core_done     = r_core_done;
  assign warp_start    = r_warp_start;
  assign warp_block_id = r_block_id;
  assign busy          = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_block_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_block_controller
// Description : Directed self-checking bench for block_controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_block_controller;
  import block_controller_pkg::*;

  logic          clk = 1'b0;
  logic          reset;
  logic          core_start;
  logic          core_reset;
  data_t         core_block_id;
  data_t         num_warps;
  logic          core_done;
  logic  [3:0]   warp_start;
  logic  [3:0]   warp_done;
  data_t         warp_block_id;
  data_t [3:0]   warp_thread_base;
  logic          busy;

  int n_cmp  = 0;
  int n_fail = 0;

  block_controller #(
    .WARPS_PER_CORE   (4),
    .THREADS_PER_WARP (8)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .core_start       (core_start),
    .core_reset       (core_reset),
    .core_block_id    (core_block_id),
    .num_warps        (num_warps),
    .core_done        (core_done),
    .warp_start       (warp_start),
    .warp_done        (warp_done),
    .warp_block_id    (warp_block_id),
    .warp_thread_base (warp_thread_base),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_bases(input string tag, input int b0, input int b1, input int b2, input int b3);
    chk({tag, "_base0"}, 32'(warp_thread_base[0]), 32'(b0));
    chk({tag, "_base1"}, 32'(warp_thread_base[1]), 32'(b1));
    chk({tag, "_base2"}, 32'(warp_thread_base[2]), 32'(b2));
    chk({tag, "_base3"}, 32'(warp_thread_base[3]), 32'(b3));
  endtask

  task automatic abort_block();
    core_start = 1'b0;
    core_reset = 1'b1;
    tick();
    core_reset = 1'b0;
  endtask

  initial begin
    // Hard reset coinciding with core_start and core_reset.
    reset = 1'b0; core_start = 1'b1; core_reset = 1'b1;
    core_block_id = 8'd7; num_warps = 8'd3; warp_done = 4'b0000;
    tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(core_done), 0);
    chk("rst_start", 32'(warp_start), 0);
    chk("rst_bid", 32'(warp_block_id), 0);
    chk_bases("rst", 0, 0, 0, 0);
    reset = 1'b1; core_start = 1'b0; core_reset = 1'b0;
    tick();
    chk("idle_busy", 32'(busy), 0);

    // Block 3, four warps; live num_warps changes after launch must not matter.
    core_block_id = 8'd3; num_warps = 8'd4; core_start = 1'b1;
    tick();
    chk("a_launch_busy", 32'(busy), 1);
    chk("a_launch_start", 32'(warp_start), 0);
    chk("a_bid", 32'(warp_block_id), 3);
    num_warps = 8'd1; core_block_id = 8'd9;
    tick();
    chk("a_start", 32'(warp_start), 4'hF);
    chk_bases("a", 96, 104, 112, 120);
    for (int i = 0; i < 4; i++) tick();
    chk("a_pre_done", 32'(core_done), 0);
    warp_done = 4'b1111;
    tick();
    warp_done = 4'b0000;
    chk("a_done", 32'(core_done), 1);
    chk("a_start_clr", 32'(warp_start), 0);
    core_start = 1'b0;
    tick(); tick();
    chk("a_done_hold", 32'(core_done), 1);
    chk("a_busy_done", 32'(busy), 1);
    abort_block();
    chk("a_rst_done", 32'(core_done), 0);
    chk("a_rst_busy", 32'(busy), 0);
    chk("a_rst_bid", 32'(warp_block_id), 3);

    // Zero warps: straight to DONE.
    core_block_id = 8'd2; num_warps = 8'd0; core_start = 1'b1;
    tick();
    chk("b_done_early", 32'(core_done), 0);
    tick();
    chk("b_done", 32'(core_done), 1);
    chk("b_start", 32'(warp_start), 0);
    abort_block();

    // Oversized request clamps to four warps.
    core_block_id = 8'd1; num_warps = 8'd9; core_start = 1'b1;
    tick(); tick();
    chk("c_start", 32'(warp_start), 4'hF);
    chk_bases("c", 32, 40, 48, 56);
    abort_block();

    // Four warps: lanes 0 and 2 together, then a repeat on lane 0.
    core_block_id = 8'd0; num_warps = 8'd4; core_start = 1'b1;
    tick(); tick();
    warp_done = 4'b0101;
    tick();
    chk("d1_pair", 32'(warp_start), 4'b1010);
    warp_done = 4'b0001;
    tick();
    chk("d1_repeat", 32'(warp_start), 4'b1010);
    chk("d1_not_done", 32'(core_done), 0);
    warp_done = 4'b1010;
    tick();
    warp_done = 4'b0000;
    chk("d1_done", 32'(core_done), 1);
    abort_block();

    // Two warps: warp_done during LAUNCH and on inactive lanes is ignored.
    core_block_id = 8'd4; num_warps = 8'd2; core_start = 1'b1;
    tick();
    warp_done = 4'b1111;
    tick();
    chk("d2_launch_ign", 32'(warp_start), 4'b0011);
    chk_bases("d2", 64, 72, 0, 0);
    warp_done = 4'b1000;
    tick();
    chk("d2_lane3_ign", 32'(warp_start), 4'b0011);
    warp_done = 4'b0101;
    tick();
    chk("d2_lane0", 32'(warp_start), 4'b0010);
    chk("d2_not_done", 32'(core_done), 0);
    warp_done = 4'b0010;
    tick();
    warp_done = 4'b0000;
    chk("d2_done", 32'(core_done), 1);
    abort_block();

    // Soft reset mid-run beats a simultaneous warp_done; then a clean block 5.
    core_block_id = 8'd6; num_warps = 8'd4; core_start = 1'b1;
    tick(); tick();
    warp_done = 4'b0011;
    tick();
    chk("e_half", 32'(warp_start), 4'b1100);
    warp_done = 4'b1100; core_start = 1'b0; core_reset = 1'b1;
    tick();
    warp_done = 4'b0000; core_reset = 1'b0;
    chk("e_abort_busy", 32'(busy), 0);
    chk("e_abort_start", 32'(warp_start), 0);
    chk("e_abort_done", 32'(core_done), 0);
    tick();
    chk("e_idle_done", 32'(core_done), 0);
    core_block_id = 8'd5; num_warps = 8'd4; core_start = 1'b1;
    tick(); tick();
    chk("e2_start", 32'(warp_start), 4'hF);
    chk_bases("e2", 160, 168, 176, 184);
    warp_done = 4'b1111;
    tick();
    warp_done = 4'b0000;
    chk("e2_done", 32'(core_done), 1);
    abort_block();

    // Hard reset mid-block abandons it silently.
    core_block_id = 8'd2; num_warps = 8'd3; core_start = 1'b1;
    tick(); tick();
    warp_done = 4'b0111; reset = 1'b0;
    tick();
    warp_done = 4'b0000; reset = 1'b1; core_start = 1'b0;
    chk("f_busy", 32'(busy), 0);
    chk("f_done", 32'(core_done), 0);
    chk("f_bid", 32'(warp_block_id), 0);
    chk("f_start", 32'(warp_start), 0);
    tick();
    chk("f_done_after", 32'(core_done), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/block_controller.md
BLOCK_CONTROLLER -- requirements
Module: block_controller

Interface
REQ-001 Parameter WARPS_PER_CORE, default 4, sets the maximum number of warps per block and the number of warp_start/warp_done lanes.
REQ-002 Parameter THREADS_PER_WARP, default 8, sets the thread-ID stride between consecutive warps.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-low, whole-block reset.
REQ-005 core_start  in  1  dispatcher request to run a block; held high while the block runs.
REQ-006 core_reset  in  1  dispatcher soft reset, synchronous, active-high; returns the block to IDLE.
REQ-007 core_block_id  in  data_t  block index; valid while core_start is high.
REQ-008 num_warps  in  data_t  warps in this block; sampled together with core_block_id.
REQ-009 core_done  out  1  block complete; returned to the dispatcher.
REQ-010 warp_start  out  WARPS_PER_CORE  per-warp run request.
REQ-011 warp_done  in  WARPS_PER_CORE  per-warp completion indication.
REQ-012 warp_block_id  out  data_t  latched block index, broadcast to all warps.
REQ-013 warp_thread_base  out  data_t[WARPS_PER_CORE]  first global thread ID of each warp.
REQ-014 busy  out  1  high in every state except IDLE.

Function
REQ-015 FSM states: IDLE, LAUNCH, RUN, DONE; encode as block_state_t.
- IDLE -> LAUNCH when core_start=1 and core_reset=0.
- LAUNCH -> RUN when the active warp count n > 0; LAUNCH -> DONE when n = 0.
- RUN -> DONE when done_mask equals active_mask.
- DONE is held until core_reset.
REQ-016 On IDLE->LAUNCH, latch core_block_id into warp_block_id and set n = min(num_warps, WARPS_PER_CORE).
REQ-017 Set active_mask bit w when w < n.
REQ-018 In LAUNCH, register the following:
- warp_thread_base[w] = block_id*n*THREADS_PER_WARP + w*THREADS_PER_WARP, truncated to data_t width.
- warp_start = active_mask.
- done_mask = 0.
REQ-019 Result: warp_start is first visible in the second cycle after core_start is first sampled high.
REQ-020 warp_thread_base for inactive lanes SHALL be 0.
REQ-021 In RUN, each cycle that warp_done[w] & active_mask[w] is high SHALL set done_mask[w] and clear warp_start[w] at the next edge.
REQ-022 warp_done on inactive lanes, or outside RUN, SHALL be ignored.
REQ-023 Repeated warp_done on an already-done lane SHALL have no effect.
REQ-024 Several lanes finishing in the same cycle SHALL all be recorded in that cycle.
REQ-025 core_done SHALL rise in the cycle after the final outstanding warp_done is sampled, and SHALL stay high through DONE until core_reset is sampled.
REQ-026 core_start being low or toggling in LAUNCH, RUN or DONE SHALL be ignored; only core_reset aborts a running block.
REQ-027 core_reset=1 in any state SHALL, at the next edge, do the following:
- enter IDLE;
- clear warp_start, done_mask and core_done;
- leave warp_block_id unchanged.
REQ-028 core_reset takes priority over a simultaneous core_start and over a simultaneous warp_done.

Reset
REQ-029 With reset=0 at a rising edge, the block SHALL enter IDLE with every output cleared: core_done=0, warp_start=0, warp_block_id=0, all warp_thread_base=0, busy=0.
REQ-030 reset SHALL take priority over core_reset and all other inputs.
REQ-031 reset asserted mid-block SHALL abandon the block silently, with no core_done pulse.

Structure
REQ-032 data_t and block_state_t SHALL reside in the shared common package.
REQ-033 Default WARPS_PER_CORE and THREADS_PER_WARP values SHALL reside in the shared common package.
REQ-034 The block SHALL be a single module with no sub-module; the lane tracking is a per-lane generate loop.
REQ-035 The multiply SHALL use the latched n, never the live num_warps input.

Verification
REQ-036 Stimulus: block_id=3, num_warps=4, each warp_done a 1-cycle pulse 5 cycles after its warp_start. Required response: warp_thread_base = 96, 104, 112, 120; core_done rises 1 cycle after the last pulse and holds until core_reset.
REQ-037 Stimulus: num_warps=0. Required response: no warp_start; core_done high 2 cycles after core_start is sampled.
REQ-038 Stimulus: num_warps=9 with WARPS_PER_CORE=4. Required response: n=4; warp_start=4'b1111.
REQ-039 Stimulus: warp_done on lanes 0 and 2 in the same cycle, on lane 3 with num_warps=2, and on lane 0 again. Required response: lanes 0 and 2 recorded together; lane 3 ignored; repeat on lane 0 ignored; core_done rises only after lane 1 completes.
REQ-040 Stimulus: core_reset in RUN while 2 of 4 warps are done. Required response: IDLE next cycle, warp_start=0, core_done never asserted; a fresh core_start with block_id=5 then runs cleanly.
REQ-041 Stimulus: reset=0 in the same cycle as core_start=1 and core_reset=1. Required response: all outputs 0 and state IDLE after the edge.
